// File: rtl/csi_rx_ctrl_pkg.sv
// csi_rx_ctrl_pkg: shared encodings for the CSI-2 RX link controller.
// State and fault codes match the STATE / ERR_CODE register values.
package csi_rx_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_SEEK  = 3'd2,
    ST_TRAIN = 3'd3,
    ST_LOCK  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_GEOM = 3'd1,
    ERR_SLIP = 3'd2,
    ERR_NOFE = 3'd3,
    ERR_NOFS = 3'd4,
    ERR_TMO  = 3'd5
  } err_t;

  typedef struct packed {
    logic [CNT_W-1:0] d0;
    logic [CNT_W-1:0] d1;
  } lane_ofs_t;

  function automatic logic [3:0] sat_inc4(
    input logic [3:0] v
  );
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/csi_rx_watchdog.sv
// csi_rx_watchdog: cycle counter that flags TIMEOUT cycles
// without a clear; expire is high while the count sits at TIMEOUT-1.
module csi_rx_watchdog
  import csi_rx_ctrl_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expire
);

  localparam logic [23:0] LAST = TIMEOUT - 24'd1;

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;

  assign expire = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 24'd1;
    if (clr || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csi_rx_link_ctrl.sv
// csi_rx_link_ctrl: sequences the CSI-2 word aligner through reset,
// training and lock, and forces a re-align with retry accounting on faults.
module csi_rx_link_ctrl
  import csi_rx_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD    = 8,
  parameter logic [23:0] TIMEOUT     = 24'd1_000_000,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned MAX_RETRY   = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic [CNT_W-1:0]  EXP_LINES,
  input  logic [CNT_W-1:0]  EXP_PIXELS,
  input  logic              DETECT,
  input  logic [CNT_W-1:0]  DET_D0,
  input  logic [CNT_W-1:0]  DET_D1,
  input  logic              FS,
  input  logic              FE,
  input  logic [CNT_W-1:0]  PIXEL_NUM,
  input  logic [CNT_W-1:0]  LINE_NUM,
  output logic              ALIGN_RST_N,
  output logic              LOCKED,
  output logic              CAPTURE_EN,
  output logic              FRAME_ERR,
  output logic [2:0]        ERR_CODE,
  output logic [2:0]        STATE,
  output logic [3:0]        RETRY_CNT,
  output logic [CNT_W-1:0]  FRAME_CNT
);

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [3:0]       good_q, good_d;
  logic             in_frame_q, in_frame_d;
  lane_ofs_t        ref_q, ref_d;
  logic [3:0]       retry_q, retry_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  err_t             err_q, err_d;
  logic             frame_err_q, frame_err_d;
  logic             align_rst_n_q, align_rst_n_d;
  logic             locked_q, locked_d;
  logic             cap_q, cap_d;

  logic      active;
  logic      tracking;
  logic      geom_ok;
  logic      fe_ok;
  logic      fault;
  err_t      fault_code;
  lane_ofs_t det_now;
  logic      wd_clr;
  logic      wd_expire;

  assign active   = ENABLE &&
                    (state_q inside {ST_SEEK, ST_TRAIN, ST_LOCK});
  assign tracking = ENABLE &&
                    (state_q inside {ST_TRAIN, ST_LOCK});
  assign det_now  = '{d0: DET_D0, d1: DET_D1};
  assign fe_ok    = FE && in_frame_q;
  assign geom_ok  =
    ((EXP_LINES == '0) || (LINE_NUM == EXP_LINES)) &&
    ((EXP_PIXELS == '0) || (PIXEL_NUM == EXP_PIXELS));

  // Any frame event or state change restarts the inactivity window.
  assign wd_clr = FS | FE | (state_d != state_q) | !active;

  csi_rx_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (CLK),
    .rst    (RST),
    .clr    (wd_clr),
    .expire (wd_expire)
  );

  // Fault arbitration: the first matching cause wins.
  always_comb begin
    fault      = 1'b0;
    fault_code = ERR_NONE;
    if (tracking && fe_ok && !geom_ok) begin
      fault      = 1'b1;
      fault_code = ERR_GEOM;
    end else if (tracking && DETECT && (det_now != ref_q)) begin
      fault      = 1'b1;
      fault_code = ERR_SLIP;
    end else if (tracking && FS && in_frame_q && !FE) begin
      fault      = 1'b1;
      fault_code = ERR_NOFE;
    end else if (tracking && FE && !in_frame_q) begin
      fault      = 1'b1;
      fault_code = ERR_NOFS;
    end else if (active && wd_expire) begin
      fault      = 1'b1;
      fault_code = ERR_TMO;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = '0;
    good_d      = good_q;
    in_frame_d  = in_frame_q;
    ref_d       = ref_q;
    retry_d     = retry_q;
    frame_cnt_d = frame_cnt_q;
    if (!ENABLE) begin
      state_d     = ST_IDLE;
      good_d      = '0;
      in_frame_d  = 1'b0;
      retry_d     = '0;
      frame_cnt_d = '0;
    end else if (fault) begin
      retry_d    = sat_inc4(retry_q);
      in_frame_d = 1'b0;
      state_d    = (retry_d >= RETRY_MAX) ? ST_FAIL : ST_RESET;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RESET;
        ST_RESET: begin
          good_d     = '0;
          in_frame_d = 1'b0;
          if (hold_q == HOLD_LAST) begin
            state_d = ST_SEEK;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        ST_SEEK: begin
          if (FS) begin
            in_frame_d = 1'b1;
            ref_d      = det_now;
            state_d    = ST_TRAIN;
          end
        end
        ST_TRAIN: begin
          // A valid FE closes the frame; a same-cycle FS reopens one.
          if (fe_ok) begin
            good_d     = good_q + 4'd1;
            in_frame_d = FS;
            if (good_d >= LOCK_N) begin
              state_d = ST_LOCK;
            end
          end else if (FS) begin
            in_frame_d = 1'b1;
          end
        end
        ST_LOCK: begin
          if (fe_ok) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            in_frame_d  = FS;
          end else if (FS) begin
            in_frame_d = 1'b1;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    align_rst_n_d =
      state_d inside {ST_SEEK, ST_TRAIN, ST_LOCK};
    locked_d    = (state_d == ST_LOCK);
    cap_d       = locked_d && in_frame_d;
    frame_err_d = fault;
    err_d       = fault ? fault_code : err_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      good_q        <= '0;
      in_frame_q    <= 1'b0;
      ref_q         <= '0;
      retry_q       <= '0;
      frame_cnt_q   <= '0;
      err_q         <= ERR_NONE;
      frame_err_q   <= 1'b0;
      align_rst_n_q <= 1'b0;
      locked_q      <= 1'b0;
      cap_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      good_q        <= good_d;
      in_frame_q    <= in_frame_d;
      ref_q         <= ref_d;
      retry_q       <= retry_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
      frame_err_q   <= frame_err_d;
      align_rst_n_q <= align_rst_n_d;
      locked_q      <= locked_d;
      cap_q         <= cap_d;
    end
  end

  assign STATE       = state_q;
  assign ALIGN_RST_N = align_rst_n_q;
  assign LOCKED      = locked_q;
  assign CAPTURE_EN  = cap_q;
  assign FRAME_ERR   = frame_err_q;
  assign ERR_CODE    = err_q;
  assign RETRY_CNT   = retry_q;
  assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_csi_rx_link_ctrl.sv
// tb_csi_rx_link_ctrl: directed bench for the CSI-2 RX link controller;
// fault pulses are matched against a queue of expected fault records.
module tb_csi_rx_link_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_SEEK  = 3'd2;
  localparam logic [2:0] S_LOCK  = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  typedef struct {
    logic [2:0] code;
    logic [3:0] retry;
    logic [2:0] state;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] exp_lines, exp_pixels;
  logic        detect;
  logic [15:0] det_d0, det_d1;
  logic        fs, fe;
  logic [15:0] pixel_num, line_num;
  logic        align_rst_n, locked, capture_en, frame_err;
  logic [2:0]  err_code, state;
  logic [3:0]  retry_cnt;
  logic [15:0] frame_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  csi_rx_link_ctrl #(
    .RST_HOLD    (8),
    .TIMEOUT     (24'd100),
    .LOCK_FRAMES (2),
    .MAX_RETRY   (7)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .ENABLE      (enable),
    .EXP_LINES   (exp_lines),
    .EXP_PIXELS  (exp_pixels),
    .DETECT      (detect),
    .DET_D0      (det_d0),
    .DET_D1      (det_d1),
    .FS          (fs),
    .FE          (fe),
    .PIXEL_NUM   (pixel_num),
    .LINE_NUM    (line_num),
    .ALIGN_RST_N (align_rst_n),
    .LOCKED      (locked),
    .CAPTURE_EN  (capture_en),
    .FRAME_ERR   (frame_err),
    .ERR_CODE    (err_code),
    .STATE       (state),
    .RETRY_CNT   (retry_cnt),
    .FRAME_CNT   (frame_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  // Each fault pulse consumes one expected record.
  always @(negedge clk) begin
    if (!rst && frame_err) begin
      if (sb_q.size() == 0) begin
        chk("spurious_err", 32'(frame_err), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("err_retry", 32'(retry_cnt), 32'(e.retry));
        chk("err_state", 32'(state), 32'(e.state));
        chk("err_cap", 32'(capture_en), 32'(0));
        chk("err_lock", 32'(locked), 32'(0));
        chk("err_arst", 32'(align_rst_n), 32'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c,
                      input logic [3:0] r,
                      input logic [2:0] s);
    exp_t e;
    e.code  = c;
    e.retry = r;
    e.state = s;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("sb_drain", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", 32'(state), 32'(s));
  endtask

  task automatic frame(input logic [15:0] l,
                       input logic [15:0] p);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    detect = 1'b1;
    tick();
    detect = 1'b0;
    tick();
    line_num  = l;
    pixel_num = p;
    fe = 1'b1;
    tick();
    fe = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, 32'(state), 32'(S_IDLE));
    chk({pfx, "_arst"}, 32'(align_rst_n), 32'(0));
    chk({pfx, "_lock"}, 32'(locked), 32'(0));
    chk({pfx, "_cap"}, 32'(capture_en), 32'(0));
    chk({pfx, "_ferr"}, 32'(frame_err), 32'(0));
    chk({pfx, "_code"}, 32'(err_code), 32'(0));
    chk({pfx, "_retry"}, 32'(retry_cnt), 32'(0));
    chk({pfx, "_fcnt"}, 32'(frame_cnt), 32'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    enable = 1'b0;
    exp_lines = 16'd4;
    exp_pixels = 16'h0A00;
    detect = 1'b0;
    det_d0 = 16'h0010;
    det_d1 = 16'h0001;
    fs = 1'b0;
    fe = 1'b0;
    line_num = 16'd4;
    pixel_num = 16'h0A00;
    repeat (3) tick();
    chk_reset_vals("por");
    rst = 1'b0;

    // Clean start and aligner reset hold
    enable = 1'b1;
    tick();
    n = 0;
    while (state === S_RESET && n < 20) begin
      if (align_rst_n !== 1'b0) begin
        chk("hold_arst", 32'(align_rst_n), 32'(0));
      end
      n++;
      tick();
    end
    chk("hold_len", 32'(n), 32'(8));
    chk("seek_state", 32'(state), 32'(S_SEEK));
    chk("seek_arst", 32'(align_rst_n), 32'(1));
    frame(16'd4, 16'h0A00);
    chk("train_unlocked", 32'(locked), 32'(0));
    frame(16'd4, 16'h0A00);
    chk("lock_after_2", 32'(locked), 32'(1));
    chk("lock_state", 32'(state), 32'(S_LOCK));
    chk("lock_fcnt0", 32'(frame_cnt), 32'(0));
    chk("lock_cap_idle", 32'(capture_en), 32'(0));

    // Capture window in LOCK
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("cap_after_fs", 32'(capture_en), 32'(1));
    tick();
    fe = 1'b1;
    chk("cap_fe_cycle", 32'(capture_en), 32'(1));
    tick();
    fe = 1'b0;
    chk("cap_after_fe", 32'(capture_en), 32'(0));
    chk("fcnt_1", 32'(frame_cnt), 32'(1));
    frame(16'd4, 16'h0A00);
    chk("fcnt_2", 32'(frame_cnt), 32'(2));

    // Geometry fault
    push(3'd1, 4'd1, S_RESET);
    frame(16'd3, 16'h0A00);
    wait_drain(4);
    wait_state(S_SEEK, 30);
    frame(16'd4, 16'h0A00);
    frame(16'd4, 16'h0A00);
    chk("relock_geom", 32'(locked), 32'(1));

    // Lane slip
    det_d0 = 16'h0020;
    detect = 1'b1;
    push(3'd2, 4'd2, S_RESET);
    tick();
    detect = 1'b0;
    det_d0 = 16'h0010;
    wait_drain(4);
    wait_state(S_SEEK, 30);
    frame(16'd4, 16'h0A00);
    frame(16'd4, 16'h0A00);
    chk("relock_slip", 32'(locked), 32'(1));
    chk("fcnt_kept", 32'(frame_cnt), 32'(2));

    // Simultaneous FS+FE while in-frame
    fs = 1'b1;
    tick();
    fs = 1'b0;
    tick();
    fs = 1'b1;
    fe = 1'b1;
    tick();
    fs = 1'b0;
    fe = 1'b0;
    chk("fsfe_state", 32'(state), 32'(S_LOCK));
    chk("fsfe_fcnt", 32'(frame_cnt), 32'(3));
    chk("fsfe_cap", 32'(capture_en), 32'(1));
    fe = 1'b1;
    tick();
    fe = 1'b0;
    chk("fsfe_close", 32'(frame_cnt), 32'(4));

    // FS twice without FE
    fs = 1'b1;
    tick();
    fs = 1'b0;
    tick();
    fs = 1'b1;
    push(3'd3, 4'd3, S_RESET);
    tick();
    fs = 1'b0;
    wait_drain(4);

    // FE without FS in TRAIN
    wait_state(S_SEEK, 30);
    frame(16'd4, 16'h0A00);
    tick();
    fe = 1'b1;
    push(3'd4, 4'd4, S_RESET);
    tick();
    fe = 1'b0;
    wait_drain(4);

    enable = 1'b0;
    tick();
    chk("dis_state", 32'(state), 32'(S_IDLE));
    chk("dis_retry", 32'(retry_cnt), 32'(0));

    // Timeout on every attempt until FAIL
    enable = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      push(3'd5, 4'(i), (i == 7) ? S_FAIL : S_RESET);
    end
    wait_drain(1000);
    chk("fail_state", 32'(state), 32'(S_FAIL));
    chk("fail_arst", 32'(align_rst_n), 32'(0));
    chk("fail_lock", 32'(locked), 32'(0));
    repeat (150) tick();
    chk("fail_stays", 32'(state), 32'(S_FAIL));
    chk("fail_retry", 32'(retry_cnt), 32'(7));
    enable = 1'b0;
    tick();
    chk("fail_exit", 32'(state), 32'(S_IDLE));
    chk("fail_rclr", 32'(retry_cnt), 32'(0));

    // FRAME_CNT wrap, one frame per cycle
    enable = 1'b1;
    wait_state(S_SEEK, 30);
    frame(16'd4, 16'h0A00);
    frame(16'd4, 16'h0A00);
    chk("wrap_lock", 32'(locked), 32'(1));
    chk("wrap_fcnt0", 32'(frame_cnt), 32'(0));
    fs = 1'b1;
    tick();
    fe = 1'b1;
    for (int k = 0; k < 65535; k++) begin
      tick();
    end
    chk("wrap_ffff", 32'(frame_cnt), 32'(16'hFFFF));
    tick();
    chk("wrap_zero", 32'(frame_cnt), 32'(0));
    chk("wrap_state", 32'(state), 32'(S_LOCK));
    fs = 1'b0;
    fe = 1'b0;
    tick();
    chk("midframe_cap", 32'(capture_en), 32'(1));

    // Reset in the middle of a locked frame
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    tick();

    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csi_rx_link_ctrl.md
# csi_rx_link_ctrl

Link controller for the 2-lane MIPI CSI-2 receiver. It sequences the word aligner: holds it in reset, releases it, and trains on incoming frames. It checks frame geometry and lane-offset stability, declares lock, and forces a re-align with retry accounting on any fault. It sits beside the word aligner, consumes its status outputs (DETECT, FS, FE, DET_D0/1, PIXEL_NUM, LINE_NUM), drives the aligner's active-low reset, and gates capture into the downstream pixel path.

## Interface
- RST_HOLD, 8: cycles ALIGN_RST_N is held low per (re)align attempt, ≥1.
- TIMEOUT, 24'd1_000_000: max cycles between FS/FE events before a timeout fault.
- LOCK_FRAMES, 2: consecutive good frames required to lock, 1..15.
- MAX_RETRY, 7: failed attempts before FAIL, 1..15.

Ports:
- CLK  in  1  receiver byte clock, the aligner's clock.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  level; 0 forces IDLE.
- EXP_LINES  in  16  expected lines per frame; 0 disables the check.
- EXP_PIXELS  in  16  expected packet word count; 0 disables the check.
- DETECT  in  1  aligner SoT-detect pulse.
- DET_D0, DET_D1  in  16  aligner one-hot lane bit offsets.
- FS, FE  in  1  aligner frame-start and frame-end pulses.
- PIXEL_NUM, LINE_NUM  in  16  aligner last word count and line count.
- ALIGN_RST_N  out  1  aligner reset, active low.
- LOCKED  out  1  link locked.
- CAPTURE_EN  out  1  downstream capture gate.
- FRAME_ERR  out  1  one-cycle fault pulse.
- ERR_CODE  out  3  cause of the last fault, sticky.
- STATE  out  3  current state.
- RETRY_CNT  out  4  failed attempts since the last ENABLE rise.
- FRAME_CNT  out  16  good frames while LOCKED; wraps at 16 bits.

## Operation
- States: IDLE=0, RESET=1, SEEK=2, TRAIN=3, LOCK=4, FAIL=5.
- IDLE: ALIGN_RST_N=0. Goes to RESET when ENABLE=1. All counters are cleared on entry from ENABLE=0.
- RESET: ALIGN_RST_N=0 for RST_HOLD cycles, then SEEK. Clears the good-frame counter, the in-frame flag and the watchdog.
- SEEK: ALIGN_RST_N=1. Waits for FS, which sets in-frame, latches DET_D0/1 as the reference offsets, and moves to TRAIN. FE in SEEK is ignored.
- TRAIN: on FE with in-frame set, the frame is good if LINE_NUM==EXP_LINES and PIXEL_NUM==EXP_PIXELS (each check skipped when its expected value is 0).
  - Good frame: increment the good counter; reaching LOCK_FRAMES goes to LOCK.
  - Bad frame: fault.
- LOCK: LOCKED=1. CAPTURE_EN=1 from the cycle after FS up to and including the FE cycle. Each good FE increments FRAME_CNT.
- Fault sources, in priority order:
  - GEOM (1): line or word count mismatch at FE.
  - SLIP (2): DETECT with DET_D0/1 different from the latched offsets (TRAIN, LOCK).
  - NOFE (3): FS while in-frame.
  - NOFS (4): FE while not in-frame (TRAIN, LOCK).
  - TMO (5): watchdog expiry (SEEK, TRAIN, LOCK).
- On a fault: FRAME_ERR pulses, ERR_CODE latches, RETRY_CNT increments (saturating at 15), LOCKED/CAPTURE_EN drop the same cycle the state changes. Next state is RESET, or FAIL if the incremented RETRY_CNT ≥ MAX_RETRY.
- Watchdog: counts cycles, cleared on FS, FE and state entry. It expires when the count equals TIMEOUT-1.
- FAIL: ALIGN_RST_N=0, LOCKED=0. Exits only via ENABLE=0 (to IDLE).
- ENABLE=0 in any state: IDLE next cycle, without flagging an error.
- FS and FE in the same cycle: FE is evaluated first against the current in-frame flag. If FE is valid, FS then opens a new frame; otherwise the fault is taken and FS is dropped.

## Timing
- All outputs are registered; inputs are sampled at CLK rising edge.
- Response to an input event (FS, FE, DETECT) is 1 cycle.
- FRAME_ERR, STATE, RETRY_CNT and ERR_CODE all update on the same edge.
- LINE_NUM and PIXEL_NUM are sampled in the FE cycle; the aligner guarantees they are valid there.
- Reset values: STATE=IDLE, ALIGN_RST_N=0, LOCKED=0, CAPTURE_EN=0, FRAME_ERR=0, ERR_CODE=0, RETRY_CNT=0, FRAME_CNT=0.
- Reset mid-frame takes effect on the next edge regardless of state.
- Fault in LOCK to ALIGN_RST_N low: 1 cycle.

## Structure
- Package csi_rx_ctrl_pkg holds the state encodings, the ERR_CODE constants, and the 16-bit count width.
- One sub-module, csi_rx_watchdog: clear input, TIMEOUT parameter, expire pulse.
- Everything else stays in one FSM block.

## Test plan
- Clean start: ENABLE=1 with RST_HOLD=8 → ALIGN_RST_N low for 8 cycles. Two frames of 4 lines / 0x0A00 words, matching EXP → LOCKED=1 one cycle after the 2nd FE; FRAME_CNT counts subsequent frames.
- Geometry fault: LOCKED, then a frame with LINE_NUM=3 against EXP_LINES=4 → FRAME_ERR pulse, ERR_CODE=1, RETRY_CNT=1, STATE=RESET, CAPTURE_EN=0.
- Slip: LOCKED with DET_D0=0x0010, then DETECT with DET_D0=0x0020 → ERR_CODE=2, re-align, re-lock after 2 good frames.
- Protocol faults: FS twice without FE → ERR_CODE=3. FE without a prior FS in TRAIN → ERR_CODE=4. Simultaneous FS+FE while in-frame → no fault, new frame opened.
- Timeout/retry: TIMEOUT=100, no FS → TMO every RESET+SEEK cycle. After 7 attempts → STATE=FAIL, ALIGN_RST_N=0. ENABLE=0 → IDLE, RETRY_CNT=0.
- Reset asserted mid-LOCK frame → all outputs at reset values on the next edge. Also check FRAME_CNT wraps from 0xFFFF to 0.
